// File: rtl/pu_shift_seq.sv
// pu_shift_seq: sequences one shift command into a pu_shift unit (init, work, oe).
// Optional: SHIFT_AUTO_STEP_EN splits each shift into 8-bit steps then 1-bit steps.
module pu_shift_seq #(
   parameter int DATA_WIDTH  = 32,
   parameter int ATTR_WIDTH  = 4,
   parameter int SHIFT_WIDTH = 5,
   parameter int PU_OUT_LAT  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [DATA_WIDTH-1:0]  cmd_data,
   input  logic [ATTR_WIDTH-1:0]  cmd_attr,
   input  logic [SHIFT_WIDTH-1:0] cmd_amount,
   input  logic                   cmd_direction,
   input  logic                   cmd_mode,
   input  logic                   cmd_step,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [DATA_WIDTH-1:0]  res_data,
   output logic [ATTR_WIDTH-1:0]  res_attr,
   output logic                   signal_work,
   output logic                   signal_direction,
   output logic                   signal_mode,
   output logic                   signal_step,
   output logic                   signal_init,
   output logic                   signal_oe,
   output logic [DATA_WIDTH-1:0]  pu_data_in,
   output logic [ATTR_WIDTH-1:0]  pu_attr_in,
   input  logic [DATA_WIDTH-1:0]  pu_data_out,
   input  logic [ATTR_WIDTH-1:0]  pu_attr_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_WORK,
      S_OE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [SHIFT_WIDTH-1:0] ONE = SHIFT_WIDTH'(1);

   state_t                  state_q, state_d;
   logic                    armed_q;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [ATTR_WIDTH-1:0]   attr_q, attr_d;
   logic [SHIFT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                    dir_q, dir_d;
   logic                    mode_q, mode_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [ATTR_WIDTH-1:0]   rattr_q, rattr_d;
   logic                    accept;

`ifdef SHIFT_AUTO_STEP_EN
   localparam logic [SHIFT_WIDTH-1:0] LO_MASK = SHIFT_WIDTH'(7);
   // hi_q: remaining 8-bit work cycles, issued before the 1-bit ones
   logic [SHIFT_WIDTH-1:0]  hi_q, hi_d;
`else
   logic                    step_q, step_d;
`endif

   assign accept = cmd_valid & cmd_ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      attr_d  = attr_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      rdata_d = rdata_q;
      rattr_d = rattr_q;
`ifdef SHIFT_AUTO_STEP_EN
      hi_d    = hi_q;
`else
      step_d  = step_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d  = cmd_data;
               attr_d  = cmd_attr;
               dir_d   = cmd_direction;
               mode_d  = cmd_mode;
`ifdef SHIFT_AUTO_STEP_EN
               hi_d    = cmd_amount >> 3;
               cnt_d   = (cmd_amount >> 3) + (cmd_amount & LO_MASK);
`else
               step_d  = cmd_step;
               cnt_d   = cmd_amount;
`endif
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            state_d = (cnt_q == '0) ? S_OE : S_WORK;
         end
         S_WORK: begin
            cnt_d = cnt_q - ONE;
`ifdef SHIFT_AUTO_STEP_EN
            if (hi_q != '0) hi_d = hi_q - ONE;
`endif
            if (cnt_q == ONE) state_d = S_OE;
         end
         S_OE: begin
            if (PU_OUT_LAT == 0) begin
               rdata_d = pu_data_out;
               rattr_d = pu_attr_out;
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            rdata_d = pu_data_out;
            rattr_d = pu_attr_out;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         armed_q <= 1'b0;
         data_q  <= '0;
         attr_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 1'b0;
         rdata_q <= '0;
         rattr_q <= '0;
`ifdef SHIFT_AUTO_STEP_EN
         hi_q    <= '0;
`else
         step_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         data_q  <= data_d;
         attr_q  <= attr_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         rdata_q <= rdata_d;
         rattr_q <= rattr_d;
`ifdef SHIFT_AUTO_STEP_EN
         hi_q    <= hi_d;
`else
         step_q  <= step_d;
`endif
      end
   end

   // PU controls decode from state_q only; armed_q holds off ready until a clock after reset
   assign cmd_ready        = armed_q & (state_q == S_IDLE);
   assign signal_init      = (state_q == S_INIT);
   assign signal_work      = (state_q == S_WORK);
   assign signal_oe        = (state_q == S_OE);
   assign signal_direction = signal_work & dir_q;
   assign signal_mode      = signal_work & mode_q;
`ifdef SHIFT_AUTO_STEP_EN
   assign signal_step      = signal_work & (hi_q != '0);
`else
   assign signal_step      = signal_work & step_q;
`endif
   assign pu_data_in       = data_q;
   assign pu_attr_in       = attr_q;
   assign res_valid        = (state_q == S_DONE);
   assign res_data         = rdata_q;
   assign res_attr         = rattr_q;

endmodule
